// File: rtl/fixmul_pkg.sv
// Shared Q-format constants and the saturate-and-flag helper for the complex multiplier.
// Rounding is selected with the FIXMUL_CPLX_ROUND_EN macro in fixmul_round_sat.
package fixmul_pkg;

   localparam int     FRAC_BITS_DEF = 17;
   localparam int     OUT_BITS_DEF  = 19;
   localparam longint ONE           = 64'sd1 <<< FRAC_BITS_DEF;
   localparam longint SAT_MAX       = (64'sd1 <<< (OUT_BITS_DEF - 1)) - 64'sd1;
   localparam longint SAT_MIN       = -(64'sd1 <<< (OUT_BITS_DEF - 1));

   typedef struct packed {
      logic [63:0] val;
      logic        sat;
   } sat_res_t;

   // Clips a wide signed value into out_bits signed range; val is returned sign-extended.
   function automatic sat_res_t sat_wide(input logic signed [63:0] v, input int out_bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           r;
      hi    = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (out_bits - 1));
      r.val = v;
      r.sat = 1'b0;
      if (v > hi) begin
         r.val = hi;
         r.sat = 1'b1;
      end else if (v < lo) begin
         r.val = lo;
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fixmul_cplx_pipe_if.sv
// Operand/result handshake bundle for fixmul_cplx_pipe; slave is the multiplier side.
interface fixmul_cplx_pipe_if
   import fixmul_pkg::*;
#(
   parameter int IN_BITS  = 19,
   parameter int OUT_BITS = 19,
   parameter int TAG_BITS = 4
);

   logic                       in_valid;
   logic                       in_ready;
   logic signed [IN_BITS-1:0]  a_re;
   logic signed [IN_BITS-1:0]  a_im;
   logic signed [IN_BITS-1:0]  b_re;
   logic signed [IN_BITS-1:0]  b_im;
   logic [TAG_BITS-1:0]        in_tag;

   logic                       out_valid;
   logic                       out_ready;
   logic signed [OUT_BITS-1:0] p_re;
   logic signed [OUT_BITS-1:0] p_im;
   logic [TAG_BITS-1:0]        out_tag;
   logic                       out_sat;
   logic                       sat_sticky;

   modport master (
      output in_valid, a_re, a_im, b_re, b_im, in_tag, out_ready,
      input  in_ready, out_valid, p_re, p_im, out_tag, out_sat, sat_sticky
   );

   modport slave (
      input  in_valid, a_re, a_im, b_re, b_im, in_tag, out_ready,
      output in_ready, out_valid, p_re, p_im, out_tag, out_sat, sat_sticky
   );

endinterface

// File: rtl/fixmul_round_sat.sv
// Combinational round/shift/saturate for one product component.
// FIXMUL_CPLX_ROUND_EN adds half an LSB before the shift; otherwise the shift truncates toward -inf.
module fixmul_round_sat
   import fixmul_pkg::*;
#(
   parameter int W_IN      = 39,
   parameter int OUT_BITS  = 19,
   parameter int FRAC_BITS = 17
) (
   input  logic signed [W_IN-1:0]     x,
   output logic signed [OUT_BITS-1:0] y,
   output logic                       sat
);

`ifdef FIXMUL_CPLX_ROUND_EN
   localparam logic signed [63:0] HALF = 64'sd1 <<< (FRAC_BITS - 1);
`endif

   logic signed [63:0] x_ext;
   logic signed [63:0] shifted;
   sat_res_t           res;
   logic               unused_hi;

   // The wide sum never overflows 64 bits, so rounding can be done before any clipping.
   always_comb begin
      x_ext = {{(64 - W_IN){x[W_IN-1]}}, x};
`ifdef FIXMUL_CPLX_ROUND_EN
      shifted = (x_ext + HALF) >>> FRAC_BITS;
`else
      shifted = x_ext >>> FRAC_BITS;
`endif
      res       = sat_wide(shifted, OUT_BITS);
      y         = res.val[OUT_BITS-1:0];
      sat       = res.sat;
      unused_hi = ^res.val[63:OUT_BITS];
   end

endmodule

// File: rtl/fixmul_cplx_pipe.sv
// Three-stage signed fixed-point complex multiplier with valid/ready, tag sideband and saturation flags.
// Rounding mode is chosen by FIXMUL_CPLX_ROUND_EN (see fixmul_round_sat).
module fixmul_cplx_pipe
   import fixmul_pkg::*;
#(
   parameter int IN_BITS   = 19,
   parameter int OUT_BITS  = 19,
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int TAG_BITS  = 4
) (
   input logic               clk,
   input logic               rst_n,
   fixmul_cplx_pipe_if.slave bus
);

   localparam int PW = 2 * IN_BITS;
   localparam int SW = 2 * IN_BITS + 1;

   logic adv;

   logic                      v1_q,   v1_d;
   logic signed [IN_BITS-1:0] ar1_q,  ar1_d;
   logic signed [IN_BITS-1:0] ai1_q,  ai1_d;
   logic signed [IN_BITS-1:0] br1_q,  br1_d;
   logic signed [IN_BITS-1:0] bi1_q,  bi1_d;
   logic [TAG_BITS-1:0]       tag1_q, tag1_d;

   logic                      v2_q,   v2_d;
   logic signed [PW-1:0]      rr_q,   rr_d;
   logic signed [PW-1:0]      ii_q,   ii_d;
   logic signed [PW-1:0]      ri_q,   ri_d;
   logic signed [PW-1:0]      ir_q,   ir_d;
   logic [TAG_BITS-1:0]       tag2_q, tag2_d;

   logic                       v3_q,     v3_d;
   logic signed [OUT_BITS-1:0] p_re_q,   p_re_d;
   logic signed [OUT_BITS-1:0] p_im_q,   p_im_d;
   logic [TAG_BITS-1:0]        tag3_q,   tag3_d;
   logic                       sat3_q,   sat3_d;
   logic                       sticky_q, sticky_d;

   logic signed [SW-1:0]       re_sum;
   logic signed [SW-1:0]       im_sum;
   logic signed [OUT_BITS-1:0] re_rs;
   logic signed [OUT_BITS-1:0] im_rs;
   logic                       re_sat;
   logic                       im_sat;

   // The whole pipe moves or holds together, so a stalled output freezes every stage.
   assign adv          = !v3_q || bus.out_ready;
   assign bus.in_ready = adv;

   always_comb begin
      v1_d   = adv ? bus.in_valid : v1_q;
      ar1_d  = ar1_q;
      ai1_d  = ai1_q;
      br1_d  = br1_q;
      bi1_d  = bi1_q;
      tag1_d = tag1_q;
      if (adv && bus.in_valid) begin
         ar1_d  = bus.a_re;
         ai1_d  = bus.a_im;
         br1_d  = bus.b_re;
         bi1_d  = bus.b_im;
         tag1_d = bus.in_tag;
      end
   end

   always_comb begin
      v2_d   = adv ? v1_q : v2_q;
      rr_d   = rr_q;
      ii_d   = ii_q;
      ri_d   = ri_q;
      ir_d   = ir_q;
      tag2_d = tag2_q;
      if (adv && v1_q) begin
         rr_d   = PW'(ar1_q) * PW'(br1_q);
         ii_d   = PW'(ai1_q) * PW'(bi1_q);
         ri_d   = PW'(ar1_q) * PW'(bi1_q);
         ir_d   = PW'(ai1_q) * PW'(br1_q);
         tag2_d = tag1_q;
      end
   end

   // One extra bit covers (-2^(n-1))^2 - (-2^(n-1))*(2^(n-1)-1) style extremes.
   always_comb begin
      re_sum = SW'(rr_q) - SW'(ii_q);
      im_sum = SW'(ri_q) + SW'(ir_q);
   end

   fixmul_round_sat #(
      .W_IN      (SW),
      .OUT_BITS  (OUT_BITS),
      .FRAC_BITS (FRAC_BITS)
   ) u_rs_re (
      .x   (re_sum),
      .y   (re_rs),
      .sat (re_sat)
   );

   fixmul_round_sat #(
      .W_IN      (SW),
      .OUT_BITS  (OUT_BITS),
      .FRAC_BITS (FRAC_BITS)
   ) u_rs_im (
      .x   (im_sum),
      .y   (im_rs),
      .sat (im_sat)
   );

   always_comb begin
      v3_d     = adv ? v2_q : v3_q;
      p_re_d   = p_re_q;
      p_im_d   = p_im_q;
      tag3_d   = tag3_q;
      sat3_d   = sat3_q;
      sticky_d = sticky_q | (v3_q && bus.out_ready && sat3_q);
      if (adv && v2_q) begin
         p_re_d = re_rs;
         p_im_d = im_rs;
         tag3_d = tag2_q;
         sat3_d = re_sat | im_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         ar1_q    <= '0;
         ai1_q    <= '0;
         br1_q    <= '0;
         bi1_q    <= '0;
         tag1_q   <= '0;
         v2_q     <= 1'b0;
         rr_q     <= '0;
         ii_q     <= '0;
         ri_q     <= '0;
         ir_q     <= '0;
         tag2_q   <= '0;
         v3_q     <= 1'b0;
         p_re_q   <= '0;
         p_im_q   <= '0;
         tag3_q   <= '0;
         sat3_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         v1_q     <= v1_d;
         ar1_q    <= ar1_d;
         ai1_q    <= ai1_d;
         br1_q    <= br1_d;
         bi1_q    <= bi1_d;
         tag1_q   <= tag1_d;
         v2_q     <= v2_d;
         rr_q     <= rr_d;
         ii_q     <= ii_d;
         ri_q     <= ri_d;
         ir_q     <= ir_d;
         tag2_q   <= tag2_d;
         v3_q     <= v3_d;
         p_re_q   <= p_re_d;
         p_im_q   <= p_im_d;
         tag3_q   <= tag3_d;
         sat3_q   <= sat3_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.out_valid  = v3_q;
   assign bus.p_re       = p_re_q;
   assign bus.p_im       = p_im_q;
   assign bus.out_tag    = tag3_q;
   assign bus.out_sat    = sat3_q;
   assign bus.sat_sticky = sticky_q;

endmodule
